// File: rtl/boron_pkg.sv
// boron_pkg: constants, state encoding and helper functions shared by the
// BORON encryption and decryption cores.
//   SBOX / INV_SBOX : 4-bit S-box and its inverse, packed so that nibble n
//                     of the constant holds the output for input n
//   ROT_W0..ROT_W3  : per-word left-rotation amounts of the round
//   KEY_ROT         : key-register rotation per schedule step
//   sbox_layer / inv_sbox_layer, key_step / inv_key_step, rotl16 / rotr16
package boron_pkg;

    localparam int KEY_W   = 80;
    localparam int BLK_W   = 64;

    localparam logic [63:0] SBOX     = 64'h6358_F02D_AC97_1B4E;
    localparam logic [63:0] INV_SBOX = 64'hB086_275C_4FD1_E93A;

    localparam int ROT_W0  = 1;
    localparam int ROT_W1  = 4;
    localparam int ROT_W2  = 7;
    localparam int ROT_W3  = 9;
    localparam int KEY_ROT = 13;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXPAND = 2'd1,
        ST_DEC    = 2'd2
    } dec_state_e;

    function automatic logic [3:0] sbox4(input logic [3:0] n);
        return SBOX[{n, 2'b00} +: 4];
    endfunction

    function automatic logic [3:0] inv_sbox4(input logic [3:0] n);
        return INV_SBOX[{n, 2'b00} +: 4];
    endfunction

    function automatic logic [15:0] rotl16(input logic [15:0] x, input int n);
        return (x << n) | (x >> (16 - n));
    endfunction

    function automatic logic [15:0] rotr16(input logic [15:0] x, input int n);
        return (x >> n) | (x << (16 - n));
    endfunction

    function automatic logic [63:0] sbox_layer(input logic [63:0] s);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) r[4*i +: 4] = sbox4(s[4*i +: 4]);
        return r;
    endfunction

    function automatic logic [63:0] inv_sbox_layer(input logic [63:0] s);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) r[4*i +: 4] = inv_sbox4(s[4*i +: 4]);
        return r;
    endfunction

    // rc is the index of the key being produced (K_rc from K_{rc-1})
    function automatic logic [79:0] key_step(input logic [79:0] k, input logic [4:0] rc);
        logic [79:0] r;
        r         = {k[KEY_W-1-KEY_ROT:0], k[KEY_W-1:KEY_W-KEY_ROT]};
        r[3:0]    = sbox4(r[3:0]);
        r[63:59]  = r[63:59] ^ rc;
        return r;
    endfunction

    // rc is the index of the key being undone (K_{rc-1} from K_rc)
    function automatic logic [79:0] inv_key_step(input logic [79:0] k, input logic [4:0] rc);
        logic [79:0] r;
        r         = k;
        r[63:59]  = r[63:59] ^ rc;
        r[3:0]    = inv_sbox4(r[3:0]);
        return {r[KEY_ROT-1:0], r[KEY_W-1:KEY_ROT]};
    endfunction

endpackage

// File: rtl/boron_inv_round.sv
// boron_inv_round: combinational inverse BORON round.
//   state_i     : round input (64 bit)
//   round_key_i : K_i applied as the final whitening of this round
//   state_o     : round output
// Undoes, in reverse order: XOR chain, word rotations, word shuffle, S-box
// layer, then adds the round key.
module boron_inv_round
    import boron_pkg::*;
(
    input  logic [63:0] state_i,
    input  logic [63:0] round_key_i,
    output logic [63:0] state_o
);

    logic [15:0] w3, w2, w1, w0;

    always_comb begin
        w3 = state_i[63:48];
        w2 = state_i[47:32];
        w1 = state_i[31:16];
        w0 = state_i[15:0];

        // forward chain was W1^=W0; W3^=W2; W0^=W3; W2^=W1
        w2 = w2 ^ w1;
        w0 = w0 ^ w3;
        w3 = w3 ^ w2;
        w1 = w1 ^ w0;

        w0 = rotr16(w0, ROT_W0);
        w1 = rotr16(w1, ROT_W1);
        w2 = rotr16(w2, ROT_W2);
        w3 = rotr16(w3, ROT_W3);

        // the pairwise word swap is its own inverse
        state_o = inv_sbox_layer({w1, w0, w3, w2}) ^ round_key_i;
    end

endmodule

// File: rtl/boron_dec_core.sv
// boron_dec_core: iterative BORON decryption, one inverse round per clock.
//   clk, reset   : clock, synchronous active-high reset
//   start        : request strobe, only looked at in IDLE
//   Key          : 80-bit master key, captured on accept
//   Cipher_Text  : ciphertext, captured on accept
//   Plain_Text   : registered result, held until the next completion
//   busy         : high from the cycle after accept until done
//   done         : one-cycle pulse when Plain_Text is valid
//
// state  | meaning
// IDLE   | waiting for start; Plain_Text holds last result
// EXPAND | forward key schedule K1..K25, K25 whitening on the last step
// DEC    | inverse rounds while unwinding the schedule back to K0
module boron_dec_core
    import boron_pkg::*;
#(
    parameter int Key_Bit_Size     = 80,
    parameter int Number_of_Rounds = 26
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [Key_Bit_Size-1:0] Key,
    input  logic [63:0]             Cipher_Text,
    output logic [63:0]             Plain_Text,
    output logic                    busy,
    output logic                    done
);

    if (Key_Bit_Size != 80) begin : g_bad_key_size
        $error("boron_dec_core: Key_Bit_Size must be 80");
    end

    localparam logic [4:0] RC_LAST = 5'(Number_of_Rounds - 1);

    dec_state_e  fsm_q, fsm_d;
    logic [79:0] key_q, key_d;
    logic [63:0] state_q, state_d;
    logic [4:0]  rc_q, rc_d;
    logic [63:0] pt_q, pt_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic [79:0] key_next;
    logic [79:0] key_prev;
    logic [63:0] round_out;

    assign key_next = key_step(key_q, rc_q);
    assign key_prev = inv_key_step(key_q, rc_q);

    boron_inv_round u_inv_round (
        .state_i     (state_q),
        .round_key_i (key_prev[63:0]),
        .state_o     (round_out)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            fsm_q   <= ST_IDLE;
            key_q   <= '0;
            state_q <= '0;
            rc_q    <= '0;
            pt_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            key_q   <= key_d;
            state_q <= state_d;
            rc_q    <= rc_d;
            pt_q    <= pt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        fsm_d   = fsm_q;
        key_d   = key_q;
        state_d = state_q;
        rc_d    = rc_q;
        pt_d    = pt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        unique case (fsm_q)
            ST_IDLE: begin
                if (start) begin
                    key_d   = Key;
                    state_d = Cipher_Text;
                    rc_d    = 5'd1;
                    busy_d  = 1'b1;
                    fsm_d   = ST_EXPAND;
                end
            end
            ST_EXPAND: begin
                key_d = key_next;
                if (rc_q == RC_LAST) begin
                    // rc stays at R: DEC starts by undoing step R
                    state_d = state_q ^ key_next[63:0];
                    fsm_d   = ST_DEC;
                end else begin
                    rc_d = rc_q + 5'd1;
                end
            end
            ST_DEC: begin
                key_d   = key_prev;
                state_d = round_out;
                rc_d    = rc_q - 5'd1;
                if (rc_q == 5'd1) begin
                    pt_d   = round_out;
                    done_d = 1'b1;
                    busy_d = 1'b0;
                    fsm_d  = ST_IDLE;
                end
            end
            default: fsm_d = ST_IDLE;
        endcase
    end

    assign Plain_Text = pt_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_boron_dec_core.sv
// Directed bench for boron_dec_core. Ciphertexts come from a local
// encryption model so every expected plaintext is a known constant.
module tb_boron_dec_core;

    logic        clk;
    logic        reset;
    logic        start;
    logic [79:0] Key;
    logic [63:0] Cipher_Text;
    logic [63:0] Plain_Text;
    logic        busy;
    logic        done;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [3:0] sb [16] = '{4'hE, 4'h4, 4'hB, 4'h1, 4'h7, 4'h9, 4'hC, 4'hA,
                            4'hD, 4'h2, 4'h0, 4'hF, 4'h8, 4'h5, 4'h3, 4'h6};

    boron_dec_core dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .Key         (Key),
        .Cipher_Text (Cipher_Text),
        .Plain_Text  (Plain_Text),
        .busy        (busy),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] rl(input logic [15:0] x, input int n);
        return (x << n) | (x >> (16 - n));
    endfunction

    function automatic logic [79:0] kfwd(input logic [79:0] k, input int r);
        logic [79:0] t;
        t = (k << 13) | (k >> 67);
        t[3:0] = sb[t[3:0]];
        t[63:59] = t[63:59] ^ 5'(r);
        return t;
    endfunction

    function automatic logic [63:0] k25_of(input logic [79:0] key);
        logic [79:0] k;
        k = key;
        for (int i = 1; i <= 25; i++) k = kfwd(k, i);
        return k[63:0];
    endfunction

    function automatic logic [63:0] enc(input logic [63:0] p, input logic [79:0] key);
        logic [79:0] k;
        logic [63:0] s;
        logic [15:0] n0, n1, n2, n3;
        k = key;
        s = p;
        for (int i = 0; i < 25; i++) begin
            s = s ^ k[63:0];
            for (int j = 0; j < 16; j++) s[4*j +: 4] = sb[s[4*j +: 4]];
            n3 = s[31:16];
            n2 = s[15:0];
            n1 = s[63:48];
            n0 = s[47:32];
            n0 = rl(n0, 1);
            n1 = rl(n1, 4);
            n2 = rl(n2, 7);
            n3 = rl(n3, 9);
            n1 = n1 ^ n0;
            n3 = n3 ^ n2;
            n0 = n0 ^ n3;
            n2 = n2 ^ n1;
            s = {n3, n2, n1, n0};
            k = kfwd(k, i + 1);
        end
        return s ^ k[63:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (done !== 1'b1 && lat < 200) begin
            tick();
            lat++;
        end
    endtask

    task automatic do_dec(input string tag, input logic [79:0] k, input logic [63:0] p);
        int lat;
        Key = k;
        Cipher_Text = enc(p, k);
        start = 1'b1;
        tick();
        start = 1'b0;
        Key = ~k;
        Cipher_Text = ~Cipher_Text;
        chk({tag, "_busy"}, 64'(busy), 64'd1);
        wait_done(lat);
        chk({tag, "_lat"}, 64'(lat), 64'd50);
        chk({tag, "_pt"}, Plain_Text, p);
        tick();
        chk({tag, "_done_pulse"}, 64'(done), 64'd0);
    endtask

    initial begin
        int lat;
        int ndone;
        int done_at;
        int prev_done;
        logic [79:0] ka, kb;
        logic [63:0] pa, pb;

        reset = 1'b1;
        start = 1'b0;
        Key = '0;
        Cipher_Text = '0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        chk("rst_pt", Plain_Text, 64'h0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);

        // zero key / zero plaintext, with key-schedule probes
        Key = '0;
        Cipher_Text = enc(64'h0, 80'h0);
        start = 1'b1;
        tick();
        start = 1'b0;
        Key = '1;
        Cipher_Text = '1;
        repeat (25) tick();
        chk("k25_after_expand", dut.key_q[63:0], k25_of(80'h0));
        wait_done(lat);
        chk("zero_lat", 64'(lat + 25), 64'd50);
        chk("zero_pt", Plain_Text, 64'h0);
        chk("zero_busy_at_done", 64'(busy), 64'd0);
        chk("k0_after_done", dut.key_q[63:0], 64'h0);
        tick();
        chk("zero_done_pulse", 64'(done), 64'd0);

        do_dec("rtrip", 80'h0123_4567_89AB_CDEF_FEDC, 64'hFEDC_BA98_7654_3210);

        // start pulses while busy must be ignored
        Key = '1;
        Cipher_Text = enc(64'h0123_4567_89AB_CDEF, 80'hFFFF_FFFF_FFFF_FFFF_FFFF);
        start = 1'b1;
        tick();
        Key = 80'h5555_AAAA_5555_AAAA_5555;
        Cipher_Text = 64'h1111_2222_3333_4444;
        ndone = 0;
        done_at = 0;
        for (int c = 1; c <= 60; c++) begin
            start = (c == 5 || c == 20 || c == 40);
            tick();
            if (done === 1'b1) begin
                ndone++;
                done_at = c;
            end
        end
        start = 1'b0;
        chk("ign_ndone", 64'(ndone), 64'd1);
        chk("ign_done_at", 64'(done_at), 64'd50);
        chk("ign_pt", Plain_Text, 64'h0123_4567_89AB_CDEF);
        chk("ign_busy", 64'(busy), 64'd0);

        // reset in the middle of DEC
        Key = 80'h0123_4567_89AB_CDEF_FEDC;
        Cipher_Text = 64'h0F0F_0F0F_0F0F_0F0F;
        start = 1'b1;
        tick();
        start = 1'b0;
        ndone = 0;
        for (int c = 1; c <= 30; c++) begin
            tick();
            if (done === 1'b1) ndone++;
        end
        reset = 1'b1;
        tick();
        chk("abort_fsm", 64'(dut.fsm_q), 64'(boron_pkg::ST_IDLE));
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_pt", Plain_Text, 64'h0);
        chk("abort_done", 64'(done), 64'd0);
        reset = 1'b0;
        tick();
        chk("abort_no_done", 64'(ndone), 64'd0);
        do_dec("after_abort", 80'h1357_9BDF_0246_8ACE_1122, 64'hDEAD_BEEF_CAFE_F00D);

        // start held high, alternating pairs A,B,A
        ka = 80'hA5A5_A5A5_A5A5_A5A5_A5A5;
        pa = 64'h0000_0000_0000_0001;
        kb = 80'h0000_0000_0000_0000_0001;
        pb = 64'hFFFF_FFFF_FFFF_FFFF;
        Key = ka;
        Cipher_Text = enc(pa, ka);
        start = 1'b1;
        tick();
        Key = kb;
        Cipher_Text = enc(pb, kb);
        prev_done = 0;
        for (int n = 0; n < 3; n++) begin
            wait_done(lat);
            chk($sformatf("b2b_done_%0d", n), 64'(done), 64'd1);
            chk($sformatf("b2b_pt_%0d", n), Plain_Text, (n % 2 == 0) ? pa : pb);
            if (n == 0) chk("b2b_lat_0", 64'(lat), 64'd50);
            else        chk($sformatf("b2b_gap_%0d", n), 64'(cyc - prev_done), 64'd51);
            prev_done = cyc;
            if (n == 2) start = 1'b0;
            tick();
            if (n % 2 == 0) begin
                Key = ka;
                Cipher_Text = enc(pa, ka);
            end else begin
                Key = kb;
                Cipher_Text = enc(pb, kb);
            end
        end
        tick();
        chk("b2b_idle_busy", 64'(busy), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/boron_dec_core.md
Name: boron_dec_core

Overview:
- Iterative single-block BORON decryption engine: 64-bit block, 80-bit key, one inverse round per clock.
- It is the inverse of the existing Boron encryption core. It sits behind the enc/dec select in the cipher wrapper and receives the Start_Dec strobe.
- Key handling: it runs the forward key schedule to the last round key, then unwinds the schedule backwards while decrypting.

Parameters:
- Key_Bit_Size, 80: key width. Only 80 is legal; any other value is an elaboration-time error.
- Number_of_Rounds, 26: number of round keys K0..K25. Cipher rounds R = Number_of_Rounds-1 = 25.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- start  in  1  request strobe; sampled only in IDLE
- Key  in  80  master key; captured on accepted start
- Cipher_Text  in  64  ciphertext; captured on accepted start
- Plain_Text  out  64  registered result; holds until the next completion
- busy  out  1  high from the cycle after accept until done
- done  out  1  one-cycle pulse when Plain_Text is valid

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high.
- Reset: FSM=IDLE; Plain_Text=0, busy=0, done=0, state_reg=0, key_reg=0, rc=0. Reset mid-operation aborts immediately; no done is produced.
- Round key K_i = key_reg[63:0]. K0 = Key[63:0].
- Forward schedule step, producing K_{i+1}:
  - key <<< 13
  - key[3:0] = S(key[3:0])
  - key[63:59] ^= (i+1) as 5 bits
- Inverse schedule step, undoing it:
  - key[63:59] ^= (i+1)
  - key[3:0] = S^-1(key[3:0])
  - key >>> 13
- S = {E,4,B,1,7,9,C,A,D,2,0,F,8,5,3,6}, indexed by input nibble.
- Words: W3=[63:48] .. W0=[15:0]. Encryption round, in order:
  - ^K_i
  - S-box on all 16 nibbles
  - shuffle (W3,W2,W1,W0) -> (W1,W0,W3,W2)
  - rotate-left W0 by 1, W1 by 4, W2 by 7, W3 by 9
  - sequential XOR: W1^=W0; W3^=W2; W0^=W3; W2^=W1
- Encryption finishes with a final ^K25.
- Inverse round: apply every step above in reverse order, each inverted. The last step is ^K_i.
- FSM: IDLE -> EXPAND -> DEC -> IDLE.
  - IDLE:
    - done=0.
    - When start=1: load key_reg=Key, state_reg=Cipher_Text, rc=1, busy=1, go to EXPAND.
  - EXPAND: one forward key step per cycle for rc=1..R.
    - On the rc=R cycle, state_reg ^= next key (K25 whitening).
    - Then go to DEC with rc=R.
  - DEC: each cycle
    - key_reg <= inverse step(key_reg, rc) = K_{rc-1}
    - state_reg <= invround(state_reg) ^ K_{rc-1}
    - rc--
    - On the rc=1 cycle: Plain_Text <= result, done<=1, busy<=0, go to IDLE.
- Latency: start sampled at edge E0 gives done high in the cycle after edge E0+2R (E50 by default). Throughput: one block per 2R+1 cycles.
- start while busy: ignored, with no queuing.
- start in the same cycle done is high: accepted (FSM is in IDLE).
- Key and Cipher_Text may change freely after the accept edge.
- rc is 5 bits and never wraps; the EXPAND/DEC counts are exact.

Decomposition:
- boron_pkg holds:
  - SBOX and INV_SBOX constants
  - rotation amounts {1,4,7,9} and KEY_ROT=13
  - functions sbox_layer, inv_sbox_layer, key_step, inv_key_step
- The encryption core shares this package.
- Sub-module boron_inv_round: combinational inverse round (state_in, round_key -> state_out).
- FSM, counter and registers stay in boron_dec_core.

Test Plan:
- Reset held, then released: Plain_Text=0, busy=0, done=0. Start with Key=0, Cipher_Text = encryption-core output for PT=0 -> done exactly 50 cycles after accept, Plain_Text=0000_0000_0000_0000.
- Round trip: Key=80'h0123_4567_89AB_CDEF_FEDC, PT=64'hFEDC_BA98_7654_3210 through the encryption core, then through this block -> Plain_Text=64'hFEDC_BA98_7654_3210, single done pulse.
- start pulsed at cycles 5, 20 and 40 after the first accept -> ignored; one done; result matches the first request.
- Reset asserted at cycle 30 of a decryption -> next cycle FSM=IDLE, busy=0, Plain_Text=0, no done. A following request completes correctly.
- start held high continuously with two alternating key/ciphertext pairs -> back-to-back results every 51 cycles, each correct.
- Key-schedule check: after EXPAND (edge E25), key_reg equals the software K25 for Key=0. After done, key_reg equals K0 = 64'h0.
